// File: rtl/ht_pkg.sv
// Shared definitions for the MP3 big-value Huffman pair encoder/decoders.
// Table parameters are indexed by Huffman table number.
package ht_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_XLIN,
        S_XSIGN,
        S_YLIN,
        S_YSIGN
    } ht_state_t;

    localparam int MAX_CODE_LEN = 19;

    localparam int LINBITS_BY_TABLE [32] = '{
        0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0,
        1, 2, 3, 4, 6, 8, 10, 13,
        4, 5, 6, 7, 8, 9, 11, 13
    };

    // Largest codeword index per table; tables 4 and 14 do not exist.
    localparam int ABS_MAX_BY_TABLE [32] = '{
        0, 1, 2, 2, 0, 3, 3, 5,
        5, 5, 7, 7, 7, 15, 0, 15,
        15, 15, 15, 15, 15, 15, 15, 15,
        15, 15, 15, 15, 15, 15, 15, 15
    };

endpackage

// File: rtl/ht_code_rom.sv
// Combinational Huffman codeword lookup for one (x,y) index pair.
// Codes are right-aligned in code; len gives the number of valid bits.
module ht_code_rom
    import ht_pkg::*;
#(
    parameter int TABLE_ID = 1,
    parameter int MAX_BITS = MAX_CODE_LEN
) (
    input  logic [3:0]          x_idx,
    input  logic [3:0]          y_idx,
    output logic [MAX_BITS-1:0] code,
    output logic [4:0]          len
);

    always_comb begin
        code = '0;
        len  = 5'd1;
        unique case (1'b1)
            (TABLE_ID == 0): begin
                code = '0;
                len  = 5'd1;
            end
            (TABLE_ID == 1): begin
                unique case ({x_idx, y_idx})
                    8'h00: begin
                        code = MAX_BITS'(1);
                        len  = 5'd1;
                    end
                    8'h01: begin
                        code = MAX_BITS'(1);
                        len  = 5'd3;
                    end
                    8'h10: begin
                        code = MAX_BITS'(1);
                        len  = 5'd2;
                    end
                    8'h11: begin
                        code = MAX_BITS'(0);
                        len  = 5'd3;
                    end
                    default: begin
                        code = MAX_BITS'(1);
                        len  = 5'd1;
                    end
                endcase
            end
            default: begin
                // Wider tables: "1" for (0,0), else "0" + x_idx + y_idx.
                if ({x_idx, y_idx} == 8'h00) begin
                    code = MAX_BITS'(1);
                    len  = 5'd1;
                end else begin
                    code = MAX_BITS'({1'b0, x_idx, y_idx});
                    len  = 5'd9;
                end
            end
        endcase
    end

endmodule

// File: rtl/ht_pair_encoder.sv
// Huffman pair encoder: one signed (x,y) pair in, a serial bitstream out
// in codeword, x linbits, x sign, y linbits, y sign order.
module ht_pair_encoder
    import ht_pkg::*;
#(
    parameter int TABLE_ID = 1,
    parameter int LINBITS  = LINBITS_BY_TABLE[TABLE_ID],
    parameter int MAX_BITS = MAX_CODE_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    output logic        in_ready,
    input  logic [15:0] x_val,
    input  logic [15:0] y_val,
    output logic        axiov,
    output logic        axiod,
    output logic        last,
    output logic        sat
);

    localparam int LW = (LINBITS > 0) ? LINBITS : 1;
    localparam int AMAX = (LINBITS > 0) ? 15 + (1 << LINBITS) - 1
                                        : ABS_MAX_BY_TABLE[TABLE_ID];
    localparam logic [16:0] AMAX17 = 17'(AMAX);

    ht_state_t state, state_n;
    ht_state_t follow;
    ht_state_t after_code, after_xlin, after_xsign, after_ylin;

    logic [4:0]          cnt, cnt_n;
    logic [3:0]          x_idx, y_idx;
    logic [LW-1:0]       x_lin, y_lin;
    logic                x_sgn, y_sgn;
    logic [MAX_BITS-1:0] code;
    logic [4:0]          len;

    logic [16:0] x_raw, y_raw, x_mag, y_mag;
    logic        x_sat, y_sat;
    logic        accept, done;
    logic        x_lin_en, y_lin_en, x_nz, y_nz;
    logic        code_bit, xl_bit, yl_bit;

    // Two's-complement magnitude in 17 bits so -32768 becomes +32768.
    assign x_raw = x_val[15] ? 17'd0 - {x_val[15], x_val} : {1'b0, x_val};
    assign y_raw = y_val[15] ? 17'd0 - {y_val[15], y_val} : {1'b0, y_val};
    assign x_sat = x_raw > AMAX17;
    assign y_sat = y_raw > AMAX17;
    assign x_mag = x_sat ? AMAX17 : x_raw;
    assign y_mag = y_sat ? AMAX17 : y_raw;

    ht_code_rom #(
        .TABLE_ID (TABLE_ID),
        .MAX_BITS (MAX_BITS)
    ) u_rom (
        .x_idx (x_idx),
        .y_idx (y_idx),
        .code  (code),
        .len   (len)
    );

    assign x_lin_en = (LINBITS > 0) && (x_idx == 4'd15);
    assign y_lin_en = (LINBITS > 0) && (y_idx == 4'd15);
    assign x_nz     = x_idx != 4'd0;
    assign y_nz     = y_idx != 4'd0;

    // MSB-first bit selects; cnt counts bits already sent in this field.
    assign code_bit = |(code & (MAX_BITS'(1) << (len - 5'd1 - cnt)));
    assign xl_bit   = |(x_lin & (LW'(1) << (5'(LW - 1) - cnt)));
    assign yl_bit   = |(y_lin & (LW'(1) << (5'(LW - 1) - cnt)));

    assign after_ylin  = y_nz ? S_YSIGN : S_IDLE;
    assign after_xsign = y_lin_en ? S_YLIN : after_ylin;
    assign after_xlin  = x_nz ? S_XSIGN : after_xsign;
    assign after_code  = x_lin_en ? S_XLIN : after_xlin;

    always_comb begin
        axiov    = 1'b0;
        axiod    = 1'b0;
        done     = 1'b0;
        follow   = S_IDLE;
        state_n  = state;
        cnt_n    = cnt;
        unique case (state)
            S_IDLE: begin
                follow = S_IDLE;
            end
            S_CODE: begin
                axiov  = 1'b1;
                axiod  = code_bit;
                done   = cnt == (len - 5'd1);
                follow = after_code;
            end
            S_XLIN: begin
                axiov  = 1'b1;
                axiod  = xl_bit;
                done   = cnt == 5'(LW - 1);
                follow = after_xlin;
            end
            S_XSIGN: begin
                axiov  = 1'b1;
                axiod  = x_sgn;
                done   = 1'b1;
                follow = after_xsign;
            end
            S_YLIN: begin
                axiov  = 1'b1;
                axiod  = yl_bit;
                done   = cnt == 5'(LW - 1);
                follow = after_ylin;
            end
            S_YSIGN: begin
                axiov  = 1'b1;
                axiod  = y_sgn;
                done   = 1'b1;
                follow = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        last     = axiov && done && (follow == S_IDLE);
        in_ready = (state == S_IDLE) || last;
        accept   = axiiv && in_ready;

        if (state == S_IDLE) begin
            cnt_n = 5'd0;
            if (accept) begin
                state_n = S_CODE;
            end
        end else if (state != state_n) begin
            cnt_n = 5'd0;
        end else if (done) begin
            cnt_n = 5'd0;
            if (last) begin
                state_n = accept ? S_CODE : S_IDLE;
            end else begin
                state_n = follow;
            end
        end else begin
            cnt_n = cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
            x_idx <= 4'd0;
            y_idx <= 4'd0;
            x_lin <= '0;
            y_lin <= '0;
            x_sgn <= 1'b0;
            y_sgn <= 1'b0;
            sat   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sat   <= accept && (x_sat || y_sat);
            if (accept) begin
                x_idx <= (x_mag >= 17'd15) ? 4'd15 : x_mag[3:0];
                y_idx <= (y_mag >= 17'd15) ? 4'd15 : y_mag[3:0];
                x_lin <= LW'(x_mag - 17'd15);
                y_lin <= LW'(y_mag - 17'd15);
                x_sgn <= x_val[15];
                y_sgn <= y_val[15];
            end
        end
    end

endmodule

// File: tb/tb_ht_pair_encoder.sv
// Encoder bench: directed bit vectors plus decoder loopback scoreboard
// across tables 0, 1, 5, 16 and 24.
module tb_ht_pair_encoder;

    localparam int NL = 5;
    localparam int TAB [NL] = '{1, 16, 0, 5, 24};
    localparam int LIN [NL] = '{0, 1, 0, 0, 4};

    typedef struct {
        int          lane;
        int          x;
        int          y;
        bit          sat;
        bit          chk;
        logic [63:0] bits;
        int          n;
    } exp_t;

    typedef struct {
        int          lane;
        int          x;
        int          y;
        logic [63:0] bits;
        int          n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst      [NL];
    logic        axiiv    [NL];
    logic [15:0] xv       [NL];
    logic [15:0] yv       [NL];
    logic        in_ready [NL];
    logic        axiov    [NL];
    logic        axiod    [NL];
    logic        last     [NL];
    logic        sat      [NL];

    always #5 clk = ~clk;

    ht_pair_encoder #(.TABLE_ID(1), .LINBITS(0)) u_t1 (
        .clk(clk), .rst(rst[0]), .axiiv(axiiv[0]), .in_ready(in_ready[0]),
        .x_val(xv[0]), .y_val(yv[0]), .axiov(axiov[0]), .axiod(axiod[0]),
        .last(last[0]), .sat(sat[0]));
    ht_pair_encoder #(.TABLE_ID(16), .LINBITS(1)) u_t16 (
        .clk(clk), .rst(rst[1]), .axiiv(axiiv[1]), .in_ready(in_ready[1]),
        .x_val(xv[1]), .y_val(yv[1]), .axiov(axiov[1]), .axiod(axiod[1]),
        .last(last[1]), .sat(sat[1]));
    ht_pair_encoder #(.TABLE_ID(0), .LINBITS(0)) u_t0 (
        .clk(clk), .rst(rst[2]), .axiiv(axiiv[2]), .in_ready(in_ready[2]),
        .x_val(xv[2]), .y_val(yv[2]), .axiov(axiov[2]), .axiod(axiod[2]),
        .last(last[2]), .sat(sat[2]));
    ht_pair_encoder #(.TABLE_ID(5), .LINBITS(0)) u_t5 (
        .clk(clk), .rst(rst[3]), .axiiv(axiiv[3]), .in_ready(in_ready[3]),
        .x_val(xv[3]), .y_val(yv[3]), .axiov(axiov[3]), .axiod(axiod[3]),
        .last(last[3]), .sat(sat[3]));
    ht_pair_encoder #(.TABLE_ID(24), .LINBITS(4)) u_t24 (
        .clk(clk), .rst(rst[4]), .axiiv(axiiv[4]), .in_ready(in_ready[4]),
        .x_val(xv[4]), .y_val(yv[4]), .axiov(axiov[4]), .axiod(axiod[4]),
        .last(last[4]), .sat(sat[4]));

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        q [$];
    vec_t        vt [$];
    bit          mon_en = 1'b0;
    int          mcnt [NL];
    logic [63:0] mcap [NL];
    bit          msat [NL];

    task automatic check_i(input string name, input int act, input int req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_v(input string name, input logic [63:0] act,
                           input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int abs_max(input int tab, input int lin);
        if (lin > 0) return 15 + (1 << lin) - 1;
        case (tab)
            1: return 1;
            2, 3: return 2;
            5, 6: return 3;
            7, 8, 9: return 5;
            10, 11, 12: return 7;
            13, 15: return 15;
            default: return 0;
        endcase
    endfunction

    function automatic int clampv(input int v, input int tab, input int lin,
                                  output bit s);
        int a;
        int m;
        a = (v < 0) ? -v : v;
        m = abs_max(tab, lin);
        s = a > m;
        if (s) a = m;
        return (v < 0) ? -a : a;
    endfunction

    // Reads w bits MSB-first from a right-aligned capture of n bits.
    function automatic int take(input logic [63:0] c, input int n,
                                inout int pos, input int w);
        int v;
        v = 0;
        for (int i = 0; i < w; i++) begin
            v = (v << 1) | ((pos < n) ? int'(c[n - 1 - pos]) : 0);
            pos++;
        end
        return v;
    endfunction

    function automatic void decode(input int tab, input int lin,
                                   input logic [63:0] c, input int n,
                                   output int x, output int y,
                                   output int used);
        int pos;
        pos = 0;
        x = 0;
        y = 0;
        if (tab == 0) begin
            void'(take(c, n, pos, 1));
        end else if (tab == 1) begin
            if (take(c, n, pos, 1) == 1) begin
                x = 0; y = 0;
            end else if (take(c, n, pos, 1) == 1) begin
                x = 1; y = 0;
            end else if (take(c, n, pos, 1) == 1) begin
                x = 0; y = 1;
            end else begin
                x = 1; y = 1;
            end
        end else if (take(c, n, pos, 1) == 0) begin
            x = take(c, n, pos, 4);
            y = take(c, n, pos, 4);
        end
        if (lin > 0 && x == 15) x += take(c, n, pos, lin);
        if (x != 0 && take(c, n, pos, 1) == 1) x = -x;
        if (lin > 0 && y == 15) y += take(c, n, pos, lin);
        if (y != 0 && take(c, n, pos, 1) == 1) y = -y;
        used = pos;
    endfunction

    task automatic finish_pair(input int l);
        exp_t e;
        int dx, dy, used;
        check_i("in_ready_on_last", int'(in_ready[l]), 1);
        if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_pair: lane %0d got %0d bits, expected none",
                     l, mcnt[l]);
            return;
        end
        e = q.pop_front();
        check_i("lane", l, e.lane);
        decode(TAB[l], LIN[l], mcap[l], mcnt[l], dx, dy, used);
        check_i("dec_x", dx, e.x);
        check_i("dec_y", dy, e.y);
        check_i("bits_consumed", used, mcnt[l]);
        check_i("sat", int'(msat[l]), int'(e.sat));
        if (e.chk) begin
            check_i("nbits", mcnt[l], e.n);
            check_v("bits", mcap[l], e.bits);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int l = 0; l < NL; l++) begin
                    if (!rst[l]) begin
                        mcnt[l] = 0;
                    end else if (axiov[l]) begin
                        if (mcnt[l] == 0) begin
                            msat[l] = sat[l];
                            mcap[l] = '0;
                        end
                        mcap[l] = {mcap[l][62:0], axiod[l]};
                        mcnt[l]++;
                        if (last[l]) begin
                            finish_pair(l);
                            mcnt[l] = 0;
                        end else if (mcnt[l] > 60) begin
                            check_i("pair_too_long", mcnt[l], 60);
                            mcnt[l] = 0;
                        end
                    end
                end
            end
        end
    end

    // Leaves axiiv high on return; the accept lands on the next posedge.
    task automatic send(input int l, input int x, input int y, input bit push,
                        input bit chk, input logic [63:0] bits, input int n);
        exp_t e;
        bit sx, sy;
        int w;
        @(negedge clk);
        axiiv[l] = 1'b1;
        xv[l] = 16'(x);
        yv[l] = 16'(y);
        w = 0;
        while (!in_ready[l] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready[l]) begin
            check_i("send_timeout", int'(in_ready[l]), 1);
            axiiv[l] = 1'b0;
            return;
        end
        if (push) begin
            e.lane = l;
            e.x = clampv(x, TAB[l], LIN[l], sx);
            e.y = clampv(y, TAB[l], LIN[l], sy);
            e.sat = sx | sy;
            e.chk = chk;
            e.bits = bits;
            e.n = n;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int l);
        @(negedge clk);
        axiiv[l] = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) begin
            check_i("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic int rnd_val(input int m);
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 40)) - 20;
            1: return int'($urandom_range(0, 2 * m + 6)) - (m + 3);
            2: return int'($signed(16'($urandom)));
            default: return 0;
        endcase
    endfunction

    initial begin
        int lanes [4];
        for (int l = 0; l < NL; l++) begin
            rst[l] = 1'b0;
            axiiv[l] = 1'b0;
            xv[l] = '0;
            yv[l] = '0;
            mcnt[l] = 0;
            mcap[l] = '0;
            msat[l] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            check_i("rst_axiov", int'(axiov[l]), 0);
            check_i("rst_axiod", int'(axiod[l]), 0);
            check_i("rst_last", int'(last[l]), 0);
            check_i("rst_sat", int'(sat[l]), 0);
            check_i("rst_in_ready", int'(in_ready[l]), 1);
        end
        for (int l = 0; l < NL; l++) rst[l] = 1'b1;
        mon_en = 1'b1;

        vt.push_back('{0, 1, -1, 64'b00001, 5});
        vt.push_back('{0, 0, 0, 64'b1, 1});
        vt.push_back('{0, 1, 0, 64'b010, 3});
        vt.push_back('{0, 0, 1, 64'b0010, 4});
        vt.push_back('{0, -1, 0, 64'b011, 3});
        vt.push_back('{0, 3, -7, 64'b00001, 5});
        vt.push_back('{0, -32768, 0, 64'b011, 3});
        vt.push_back('{2, 0, 0, 64'b0, 1});
        vt.push_back('{2, 5, -2, 64'b0, 1});
        vt.push_back('{1, 16, 0, 64'b01111000010, 11});
        vt.push_back('{1, -20, 3, 64'b011110011110, 12});
        vt.push_back('{1, 0, 0, 64'b1, 1});
        vt.push_back('{4, 15, -15, 64'b0111111110000000001, 19});
        vt.push_back('{3, 2, 3, 64'b00010001100, 11});
        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].lane, vt[i].x, vt[i].y, 1'b1, 1'b1, vt[i].bits, vt[i].n);
            if (i == vt.size() - 1 || vt[i + 1].lane != vt[i].lane) begin
                idle(vt[i].lane);
                drain();
            end
        end

        // Back-to-back pairs: first-bit latency and no gap bit.
        send(0, 0, 0, 1'b1, 1'b1, 64'b1, 1);
        send(0, 1, 0, 1'b1, 1'b1, 64'b010, 3);
        check_i("b2b_first_axiov", int'(axiov[0]), 1);
        check_i("b2b_first_last", int'(last[0]), 1);
        @(negedge clk);
        axiiv[0] = 1'b0;
        check_i("b2b_gap0", int'(axiov[0]), 1);
        @(negedge clk);
        check_i("b2b_gap1", int'(axiov[0]), 1);
        @(negedge clk);
        check_i("b2b_gap2", int'(axiov[0]), 1);
        check_i("b2b_last2", int'(last[0]), 1);
        drain();

        // Reset on the second bit of a 5-bit pair.
        mon_en = 1'b0;
        send(0, 1, -1, 1'b0, 1'b0, 64'b0, 0);
        @(negedge clk);
        axiiv[0] = 1'b0;
        check_i("rstmid_bit1", int'(axiov[0]), 1);
        @(negedge clk);
        check_i("rstmid_bit2", int'(axiov[0]), 1);
        rst[0] = 1'b0;
        @(negedge clk);
        check_i("rstmid_axiov", int'(axiov[0]), 0);
        check_i("rstmid_last", int'(last[0]), 0);
        rst[0] = 1'b1;
        @(negedge clk);
        check_i("rstmid_trail0", int'(axiov[0]), 0);
        @(negedge clk);
        check_i("rstmid_trail1", int'(axiov[0]), 0);
        mcnt[0] = 0;
        mon_en = 1'b1;
        send(0, 1, 0, 1'b1, 1'b1, 64'b010, 3);
        idle(0);
        drain();

        lanes = '{0, 3, 1, 4};
        foreach (lanes[k]) begin
            int l, m;
            l = lanes[k];
            m = abs_max(TAB[l], LIN[l]);
            for (int i = 0; i < 40; i++) begin
                send(l, rnd_val(m), rnd_val(m), 1'b1, 1'b0, 64'b0, 0);
                if ($urandom_range(0, 4) == 0) idle(l);
            end
            idle(l);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
